// File: rtl/vip_pkg.sv
// vip_pkg: luma coefficients, output levels, update FSM states and RGB565 luma helpers.
package vip_pkg;
    localparam logic [7:0]  COEF_R = 8'd77;
    localparam logic [7:0]  COEF_G = 8'd150;
    localparam logic [7:0]  COEF_B = 8'd29;
    localparam logic [15:0] BLACK  = 16'h0000;
    localparam logic [15:0] WHITE  = 16'hFFFF;
    typedef enum logic [1:0] {ACC, MUL, CLAMP} state_t;
    function automatic logic [47:0] weigh(input logic [15:0] p);
        return {16'(COEF_R) * 16'({p[15:11], p[15:13]}),
                16'(COEF_G) * 16'({p[10:5], p[10:9]}),
                16'(COEF_B) * 16'({p[4:0], p[4:2]})};
    endfunction
    function automatic logic [7:0] luma_sum(input logic [47:0] w);
        logic [15:0] s;
        s = w[47:32] + w[31:16] + w[15:0];
        return s[15:8];
    endfunction
endpackage

// File: rtl/rgb565_to_gray.sv
// rgb565_to_gray: two-stage RGB565 to 8-bit luma pipeline (weigh, then sum and shift).
module rgb565_to_gray
    import vip_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] rgb,
    output logic        out_valid,
    output logic [7:0]  y
);
    logic [47:0] w_q, w_d;
    logic [7:0]  y_q, y_d;
    logic [1:0]  v_q, v_d;
    always_comb begin
        w_d = weigh(rgb);
        y_d = luma_sum(w_q);
        v_d = {v_q[0], in_valid};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q <= '0;
            y_q <= '0;
            v_q <= '0;
        end else begin
            w_q <= w_d;
            y_q <= y_d;
            v_q <= v_d;
        end
    end
    assign out_valid = v_q[1];
    assign y         = y_q;
endmodule

// File: rtl/vip_adaptive_binarization.sv
// vip_adaptive_binarization: binarizes RGB565 pixels against the previous frame's mean luma.
module vip_adaptive_binarization
    import vip_pkg::*;
#(
    parameter int unsigned       EXP_PIXELS = 921600,
    parameter logic [31:0]       RECIP      = 32'd4660,
    parameter logic [7:0]        INIT_THR   = 8'd128,
    parameter logic signed [8:0] THR_OFFSET = 9'sd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pre_frame_vsync,
    input  logic        pre_frame_href,
    input  logic        pre_frame_de,
    input  logic [15:0] pre_rgb,
    input  logic        mode_fixed,
    input  logic [7:0]  fixed_thr,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_de,
    output logic [15:0] post_rgb,
    output logic [7:0]  cur_thr,
    output logic        frame_err
);
    logic [2:0]        vs_q, vs_d, hr_q, hr_d, de_q, de_d;
    logic              vs_prev_q, vs_prev_d, err_q, err_d;
    logic [15:0]       rgb_q, rgb_d;
    logic [7:0]        thr_q, thr_d, y, y_in, mean;
    logic [27:0]       sum_q, sum_d, snap_q, snap_d, prod_q, prod_d, base_sum;
    logic [19:0]       cnt_q, cnt_d, base_cnt;
    logic [28:0]       acc;
    logic signed [9:0] t;
    logic              y_valid, edge_s;
    state_t            st_q, st_d;
    rgb565_to_gray u_gray (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (pre_frame_de),
        .rgb       (pre_rgb),
        .out_valid (y_valid),
        .y         (y)
    );
    always_comb begin
        edge_s    = pre_frame_vsync & ~vs_prev_q;
        vs_prev_d = pre_frame_vsync;
        vs_d      = {vs_q[1:0], pre_frame_vsync};
        hr_d      = {hr_q[1:0], pre_frame_href};
        de_d      = {de_q[1:0], pre_frame_de};
        rgb_d     = (y_valid && y > (mode_fixed ? fixed_thr : thr_q)) ? WHITE : BLACK;
        // accumulation uses a direct luma of the input so a same-cycle pixel lands in the new frame
        y_in      = luma_sum(weigh(pre_rgb));
        base_sum  = edge_s ? 28'd0 : sum_q;
        base_cnt  = edge_s ? 20'd0 : cnt_q;
        acc       = {1'b0, base_sum} + {21'd0, y_in};
        sum_d     = pre_frame_de ? (acc[28] ? {28{1'b1}} : acc[27:0]) : base_sum;
        cnt_d     = (pre_frame_de && ~&base_cnt) ? base_cnt + 20'd1 : base_cnt;
        snap_d    = edge_s ? sum_q : snap_q;
        err_d     = edge_s && (st_q != ACC || cnt_q != 20'(EXP_PIXELS));
        prod_d    = st_q == MUL ? 28'((60'(snap_q) * 60'(RECIP)) >> 32) : prod_q;
        mean      = |prod_q[27:8] ? 8'hFF : prod_q[7:0];
        t         = $signed({2'b00, mean}) + $signed({THR_OFFSET[8], THR_OFFSET});
        thr_d     = st_q == CLAMP ? (t[9] ? 8'd0 : t[8] ? 8'hFF : t[7:0]) : thr_q;
        st_d      = st_q == MUL ? CLAMP : st_q == CLAMP ? ACC :
                    (edge_s && cnt_q == 20'(EXP_PIXELS)) ? MUL : ACC;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q      <= '0;
            hr_q      <= '0;
            de_q      <= '0;
            vs_prev_q <= 1'b0;
            rgb_q     <= BLACK;
            sum_q     <= '0;
            cnt_q     <= '0;
            snap_q    <= '0;
            prod_q    <= '0;
            err_q     <= 1'b0;
            thr_q     <= INIT_THR;
            st_q      <= ACC;
        end else begin
            vs_q      <= vs_d;
            hr_q      <= hr_d;
            de_q      <= de_d;
            vs_prev_q <= vs_prev_d;
            rgb_q     <= rgb_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            snap_q    <= snap_d;
            prod_q    <= prod_d;
            err_q     <= err_d;
            thr_q     <= thr_d;
            st_q      <= st_d;
        end
    end
    assign post_frame_vsync = vs_q[2];
    assign post_frame_href  = hr_q[2];
    assign post_frame_de    = de_q[2];
    assign post_rgb         = rgb_q;
    assign cur_thr          = thr_q;
    assign frame_err        = err_q;
endmodule

// File: tb/tb_vip_adaptive_binarization.sv
// tb_vip_adaptive_binarization: directed frames on three offset variants, scoreboarded pixel outputs.
module tb_vip_adaptive_binarization;
    import vip_pkg::*;
    localparam int unsigned EXP = 32;
    localparam logic [31:0] RCP = 32'h0800_0000;
    localparam logic [15:0] GRAY = 16'h8410;
    typedef struct {
        logic [15:0] v;
        int          c;
    } exp_t;
    logic        clk = 1'b0, rst = 1'b0;
    logic        vs = 1'b0, hr = 1'b0, de = 1'b0, mode = 1'b0;
    logic [15:0] rgb = '0;
    logic [7:0]  fthr = '0;
    logic [2:0]  o_vs, o_hr, o_de, o_fe;
    logic [15:0] o_rgb [3];
    logic [7:0]  thr [3];
    exp_t        q[$];
    int          cyc = 0, checks = 0, fails = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        vip_adaptive_binarization #(
            .EXP_PIXELS (EXP),
            .RECIP      (RCP),
            .INIT_THR   (8'd128),
            .THR_OFFSET (g == 0 ? 9'sd0 : g == 1 ? -9'sd200 : 9'sd200)
        ) u_dut (
            .clk              (clk),
            .rst              (rst),
            .pre_frame_vsync  (vs),
            .pre_frame_href   (hr),
            .pre_frame_de     (de),
            .pre_rgb          (rgb),
            .mode_fixed       (mode),
            .fixed_thr        (fthr),
            .post_frame_vsync (o_vs[g]),
            .post_frame_href  (o_hr[g]),
            .post_frame_de    (o_de[g]),
            .post_rgb         (o_rgb[g]),
            .cur_thr          (thr[g]),
            .frame_err        (o_fe[g])
        );
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (o_de[0]) begin
            chk("pending_entry", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("post_rgb", o_rgb[0], e.v);
                chk("latency", cyc, e.c + 3);
                chk("post_href", o_hr[0], 1);
            end
        end
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input int n);
        de = 1'b0;
        hr = 1'b0;
        vs = 1'b0;
        repeat (n) tick();
    endtask
    task automatic pix(input int n, input logic [15:0] p, input logic [15:0] e);
        repeat (n) begin
            rgb = p;
            de  = 1'b1;
            hr  = 1'b1;
            q.push_back('{e, cyc});
            tick();
        end
        de = 1'b0;
        hr = 1'b0;
    endtask
    task automatic thr_chk(input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] t2);
        chk("cur_thr_off0", thr[0], t0);
        chk("cur_thr_offm200", thr[1], t1);
        chk("cur_thr_offp200", thr[2], t2);
    endtask
    task automatic vsync(input logic err, input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] t2);
        idle(2);
        vs = 1'b1;
        tick();
        chk("frame_err", o_fe[0], 32'(err));
        vs = 1'b0;
        tick();
        chk("frame_err_pulse_end", o_fe[0], 0);
        tick();
        thr_chk(t0, t1, t2);
        chk("post_vsync_delay", o_vs[0], 1);
        idle(3);
    endtask
    task automatic rst_chk;
        for (int i = 0; i < 3; i++) begin
            chk("rst_post_rgb", o_rgb[i], 0);
            chk("rst_post_de", o_de[i], 0);
            chk("rst_post_vsync", o_vs[i], 0);
            chk("rst_post_href", o_hr[i], 0);
            chk("rst_frame_err", o_fe[i], 0);
            chk("rst_cur_thr", thr[i], 128);
        end
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end
    initial begin
        #2 rst = 1'b1;
        #1 rst_chk();
        tick();
        tick();
        rst = 1'b0;
        pix(32, WHITE, WHITE);
        vsync(1'b0, 8'd255, 8'd55, 8'd255);
        pix(32, GRAY, BLACK);
        vsync(1'b0, 8'd130, 8'd0, 8'd255);
        pix(16, WHITE, WHITE);
        pix(16, BLACK, BLACK);
        vsync(1'b0, 8'd127, 8'd0, 8'd255);
        pix(31, GRAY, WHITE);
        vsync(1'b1, 8'd127, 8'd0, 8'd255);
        pix(32, BLACK, BLACK);
        idle(2);
        vs = 1'b1;
        tick();
        chk("err_first_edge", o_fe[0], 0);
        vs = 1'b0;
        tick();
        vs = 1'b1;
        tick();
        chk("err_busy_edge", o_fe[0], 1);
        thr_chk(8'd0, 8'd0, 8'd200);
        idle(4);
        mode = 1'b1;
        fthr = 8'd200;
        pix(16, GRAY, BLACK);
        idle(3);
        fthr = 8'd130;
        pix(8, GRAY, BLACK);
        idle(3);
        fthr = 8'd129;
        pix(8, GRAY, WHITE);
        vsync(1'b0, 8'd130, 8'd0, 8'd255);
        mode = 1'b0;
        pix(10, WHITE, WHITE);
        rst = 1'b1;
        #1 rst_chk();
        q.delete();
        tick();
        rst = 1'b0;
        pix(16, GRAY, WHITE);
        pix(16, BLACK, BLACK);
        vsync(1'b0, 8'd65, 8'd0, 8'd255);
        idle(5);
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/vip_adaptive_binarization.md
# vip_adaptive_binarization

Per-frame adaptive binarization stage for the OV5640 → DDR3 → HDMI camera path. It sits in the `vip` pixel pipeline between the CMOS capture (RGB565 pixel stream) and the DDR3 write port. It converts each pixel to 8-bit luma and outputs white (16'hFFFF) or black (16'h0000) against a threshold. The threshold is the mean luma of the previous complete frame plus a signed offset, or a fixed software value.

## Interface
- `EXP_PIXELS`, default 921600: pixels per complete frame (1280×720).
- `RECIP`, default 4660: round(2^32 / EXP_PIXELS), the reciprocal used for the mean.
- `INIT_THR`, default 128: threshold after reset.
- `THR_OFFSET`, default 0: signed 9-bit value added to the mean.

Ports:
- `clk` in 1: pixel clock (cam_pclk domain).
- `rst` in 1: asynchronous, active-high reset.
- `pre_frame_vsync` in 1: frame sync; active-high pulse at frame start.
- `pre_frame_href` in 1: line valid.
- `pre_frame_de` in 1: pixel valid.
- `pre_rgb` in 16: RGB565 pixel.
- `mode_fixed` in 1: 1 = use `fixed_thr`; 0 = adaptive.
- `fixed_thr` in 8: fixed threshold.
- `post_frame_vsync` out 1: `pre_frame_vsync` delayed 3 cycles.
- `post_frame_href` out 1: `pre_frame_href` delayed 3 cycles.
- `post_frame_de` out 1: `pre_frame_de` delayed 3 cycles.
- `post_rgb` out 16: 16'hFFFF or 16'h0000.
- `cur_thr` out 8: threshold currently in use.
- `frame_err` out 1: one-cycle pulse when a frame boundary arrives with pixel count ≠ EXP_PIXELS.

## Operation
- **Expansion:** R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
- **Luma:** Y=(77·R8+150·G8+29·B8)>>8. The sum is 16 bits; Y is 8 bits and never exceeds 255.
- **Compare:** `post_rgb`=16'hFFFF if Y > thr_eff, else 16'h0000.
  - thr_eff = `fixed_thr` when `mode_fixed`=1, else `cur_thr`.
  - `mode_fixed` is sampled at the compare stage.
- **Accumulator:** while `pre_frame_de`=1, add Y to a 28-bit `sum` and increment a 20-bit `cnt`. Both saturate at all-ones.
- **Frame boundary:** the rising edge of `pre_frame_vsync`, detected against a registered copy.
  - Snapshot `sum`/`cnt`, then clear both.
  - If `pre_frame_de`=1 on the same cycle, that pixel counts into the new frame.
- **Update FSM:** states ACC → MUL → CLAMP → ACC.
  - ACC: wait for a boundary. If snapshot cnt == EXP_PIXELS, go to MUL. Otherwise pulse `frame_err` and stay in ACC with the threshold unchanged.
  - MUL: mean = (snap_sum × RECIP) >> 32, a registered 60-bit product.
  - CLAMP: t = mean + THR_OFFSET in signed 10-bit arithmetic, clamped to 0..255, loaded into `cur_thr`.
  - A new boundary arriving while in MUL or CLAMP is still snapshotted. Its update is dropped and `frame_err` is pulsed.
- **Reset (asynchronous):** all outputs 0; `cur_thr`=INIT_THR; sum, cnt and pipeline cleared; FSM in ACC. A reset mid-frame discards the partial frame.

## Timing
- The data path has a fixed 3-cycle latency from `pre_*` to `post_*`:
  - stage 1: expand and multiply;
  - stage 2: sum and shift;
  - stage 3: compare.
- Sync signals are delayed through a matching 3-stage shift register.
- `cur_thr` updates 3 cycles after the vsync rising edge: edge detect, MUL, CLAMP. Frame blanking covers this, so every pixel of a frame sees one constant threshold.
- `frame_err` is asserted 1 cycle after the boundary edge.
- No backpressure; one pixel per cycle max.

## Structure
- Package `vip_pkg`:
  - luma coefficients 77/150/29;
  - BLACK = 16'h0000 and WHITE = 16'hFFFF;
  - FSM state enum {ACC, MUL, CLAMP}.
- Sub-module `rgb565_to_gray`: 2-stage pipeline, RGB565 in, Y out with a valid flag. The compare stage, accumulator and FSM stay in the top.
- Target size about 200 lines RTL.

## Test plan
Benches use EXP_PIXELS=32 and RECIP=2^27 (8×4 frames) unless stated otherwise.
- **White frame:** reset, then 32 pixels of 16'hFFFF. Required:
  - `post_rgb`=FFFF, 3 cycles after each `de`;
  - after the next vsync, `cur_thr`=255 within 3 cycles.
- **Mid-gray frame:** then 32 pixels of 16'h8410 (Y=130) against thr 255. Required:
  - `post_rgb`=0000;
  - on the next vsync, `cur_thr`=130.
- **Half/half frame:** 16 pixels FFFF and 16 pixels 0000. Required: mean 4080/32 = 127, so `cur_thr`=127. With THR_OFFSET=−200 the clamp gives `cur_thr`=0; with +200 it gives 255.
- **Short frame:** 31 pixels, then vsync. Required: `frame_err` 1-cycle pulse and `cur_thr` unchanged. Also: a vsync during MUL drops that update with a `frame_err` pulse.
- **Fixed mode:** `mode_fixed`=1, `fixed_thr`=200 on 0x8410 pixels. Required: `post_rgb`=0000, while the adaptive `cur_thr` keeps updating in the background.
- **Reset mid-frame:** `rst` asserted after 10 pixels. Required:
  - immediately: `post_*`=0 and `cur_thr`=128;
  - the next full frame computes the mean from that frame only.
